bcd_serial_adder: RTL and testbench
===================================

Name: bcd_serial_adder

Overview:
- Multi-digit BCD adder/subtractor; processes one BCD digit per clock, least-significant digit (LSD) first.
- Generalises the single-digit BCD add: parametrised digit count, carry chaining between digits, ten's-complement subtract mode, start/busy/done handshake, invalid-digit error.
- Sits between the switch/operand registers and the per-digit 7-segment decoders.
- One digit-adder slice (binary add + >9 correction) is reused serially across all digits.

Parameters:
- DIGITS, 4, number of BCD digits per operand (legal range 1..8).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request a new operation; sampled only in IDLE.
- Sub  in  1  0 = A+B+Cin, 1 = A-B (ten's complement); sampled with Start.
- Cin  in  1  carry-in to the LSD; ignored when Sub=1.
- A  in  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- B  in  4*DIGITS  operand B, packed BCD.
- S  out  4*DIGITS  result, packed BCD.
- Cout  out  1  carry out of the MSD; in subtract mode 1 means A>=B (no borrow).
- Busy  out  1  high while in ADD or DONE.
- Done  out  1  one-cycle pulse when S, Cout and Err are valid.
- Err  out  1  an operand held a digit >9 at capture.

Behaviour:
- Reset, checked at every edge with priority over all else, sets the following:
  - state = IDLE
  - S = 0, Cout = 0, Busy = 0, Done = 0, Err = 0
  - internal operand, index and carry registers = 0
- Reset asserted mid-operation aborts the operation with no Done pulse.
- States: IDLE, ADD, DONE.
- IDLE, on an edge with Start=1:
  - Latch A, B, Sub.
  - Set carry = Sub ? 1 : Cin.
  - Set digit index i = 0.
  - Clear S, Cout, Err.
  - Compute Err = 1 if any latched A or B digit is >9.
  - If Err: go to DONE and skip ADD; S=0, Cout=0.
  - Else: go to ADD.
- While Busy, Start is ignored. Operand inputs may change freely after the capture edge.
- ADD, each edge:
  - b' = Sub ? (9 - B[i]) : B[i].
  - t = A[i] + b' + carry, 5-bit binary.
  - If t > 9: digit = t - 10 (low 4 bits of t+6) and carry = 1. Else: digit = t and carry = 0.
  - Write digit to S[4i+3:4i]. Increment i.
  - When i = DIGITS-1 is processed: Cout = carry, go to DONE.
- DONE:
  - Done=1 and Busy=1 for exactly one cycle.
  - Next state is IDLE. A Start on this edge is ignored.
- Latency: Start is sampled at edge 0; Done is high in the cycle following edge DIGITS. Total occupancy is DIGITS+1 cycles. Back-to-back Start is accepted on the first cycle of IDLE.
- S digits above index i hold 0 during ADD. S, Cout and Err hold their values from DONE until the next accepted Start or Reset.
- Max sum, add mode: 10^DIGITS - 1 + 10^DIGITS - 1 + 1, giving all-9s S with Cout=1. No other overflow indication.
- Subtract mode:
  - Result S is (A - B) mod 10^DIGITS.
  - If Cout=0, S is the ten's complement of |A-B| (negative result). The block does not re-complement.
- DIGITS=1: ADD lasts one cycle; behaviour is otherwise identical.

Test Plan (DIGITS=4 unless stated):
- Add: A=1234, B=5678, Sub=0, Cin=0, pulse Start -> Done high exactly 5 cycles after the Start edge, Busy high 5 cycles, S=6912, Cout=0, Err=0.
- Carry chain: A=9999, B=0000, Cin=1 -> S=0000, Cout=1; repeat with B=9999, Cin=1 -> S=9999, Cout=1.
- Subtract: A=0500, B=0123, Sub=1 -> S=0377, Cout=1; A=0123, B=0500, Sub=1 -> S=9623, Cout=0; Cin=1 has no effect in either.
- Invalid digit: A=00A0 (hex nibble 10), B=0001 -> Done 1 cycle after the Start edge, Err=1, S=0000, Cout=0; the next valid op clears Err.
- Handshake:
  - Start held high through an operation, with A/B changed after capture -> result uses the captured operands.
  - Second op starts only after the IDLE cycle.
  - Start held continuously -> one op every 6 cycles.
- Reset mid-op: Reset asserted in the 2nd ADD cycle -> next cycle all outputs 0, no Done; new Start completes normally.
- Parameter sweep: DIGITS=1 (A=7, B=5 -> S=2, Cout=1, Done at cycle 2) and DIGITS=8 (A=99999999, B=1 -> S=0, Cout=1, Done at cycle 9).

Source files
------------

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder/subtractor that handles one digit per clock, least-significant digit first.
// A single digit slice (binary add followed by a >9 correction) is reused serially across all DIGITS.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic                cin,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic [4*DIGITS-1:0] s,
    output logic                cout,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, state_next;
    logic [W-1:0]     a_q, b_q;
    logic             sub_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       a_dig, b_dig;
    logic [4:0]       slice;
    logic             bad_digit;

    // Returns {carry, digit}; t > 9 is corrected by adding 6 and keeping the low nibble.
    function automatic logic [4:0] bcd_slice(input logic [3:0] x, input logic [3:0] y,
                                             input logic c);
        logic [4:0] t;
        t = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        if (t > 5'd9) return {1'b1, t[3:0] + 4'd6};
        else          return {1'b0, t[3:0]};
    endfunction

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++)
            if (v[4*k +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    always_comb begin
        a_dig     = a_q[4*int'(idx_q) +: 4];
        // Subtraction adds the nine's complement of B; the initial carry of 1 turns it into ten's complement.
        b_dig     = sub_q ? (4'd9 - b_q[4*int'(idx_q) +: 4]) : b_q[4*int'(idx_q) +: 4];
        slice     = bcd_slice(a_dig, b_dig, carry_q);
        bad_digit = has_bad_digit(a) | has_bad_digit(b);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = bad_digit ? DONE : ADD;
            ADD:     if (idx_q == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s       <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= sub;
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        s       <= '0;
                        cout    <= 1'b0;
                        err     <= bad_digit;
                    end
                end
                ADD: begin
                    s[4*int'(idx_q) +: 4] <= slice[3:0];
                    carry_q               <= slice[4];
                    if (idx_q == LAST_IDX) begin
                        idx_q <= '0;
                        cout  <= slice[4];
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder: a table of 4-digit operations plus handshake, reset-abort
// and DIGITS=1 / DIGITS=8 sequences.
module tb_bcd_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sub, cin;
    logic [15:0] a, b, s;
    logic        cout, busy, done, err;

    logic        start1, busy1, done1, err1, cout1;
    logic [3:0]  a1, b1, s1;
    logic        start8, busy8, done8, err8, cout8;
    logic [31:0] a8, b8, s8;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] s;
        logic        cout;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
        .s(s), .cout(cout), .busy(busy), .done(done), .err(err)
    );

    bcd_serial_adder #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(1'b0), .cin(1'b0), .a(a1), .b(b1),
        .s(s1), .cout(cout1), .busy(busy1), .done(done1), .err(err1)
    );

    bcd_serial_adder #(.DIGITS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(1'b0), .cin(1'b0), .a(a8), .b(b8),
        .s(s8), .cout(cout8), .busy(busy8), .done(done8), .err(err8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; pulses start for one edge and waits (bounded) for done.
    task automatic run4(input logic [15:0] ta, input logic [15:0] tb_val, input logic tsub,
                        input logic tcin, output int lat, output int busy_cnt);
        a = ta; b = tb_val; sub = tsub; cin = tcin; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        busy_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat, bcnt, n, m, dcnt;

        vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 5};
        vecs[1]  = '{16'h9999, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 5};
        vecs[2]  = '{16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, 5};
        vecs[3]  = '{16'h0500, 16'h0123, 1'b1, 1'b0, 16'h0377, 1'b1, 1'b0, 5};
        vecs[4]  = '{16'h0500, 16'h0123, 1'b1, 1'b1, 16'h0377, 1'b1, 1'b0, 5};
        vecs[5]  = '{16'h0123, 16'h0500, 1'b1, 1'b0, 16'h9623, 1'b0, 1'b0, 5};
        vecs[6]  = '{16'h0123, 16'h0500, 1'b1, 1'b1, 16'h9623, 1'b0, 1'b0, 5};
        vecs[7]  = '{16'h00A0, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1};
        vecs[8]  = '{16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 5};
        vecs[9]  = '{16'h0999, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 5};
        vecs[10] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 5};
        vecs[11] = '{16'h0001, 16'h000B, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1};
        vecs[12] = '{16'h4821, 16'h3179, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 5};

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        start1 = 1'b0; a1 = '0; b1 = '0; start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_d1", {s1, cout1, busy1, done1, err1}, 0);
        chk("rst_d8", {s8, cout8, busy8, done8, err8}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run4(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, lat, bcnt);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy", i), bcnt, vecs[i].lat);
            chk($sformatf("v%0d_s", i), s, vecs[i].s);
            chk($sformatf("v%0d_cout", i), cout, vecs[i].cout);
            chk($sformatf("v%0d_err", i), err, vecs[i].err);
            @(negedge clk);
            chk($sformatf("v%0d_idle", i), {busy, done}, 0);
            chk($sformatf("v%0d_hold_s", i), s, vecs[i].s);
        end

        // Start held high; operands change after capture; one op every 6 cycles.
        a = 16'h1234; b = 16'h5678; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (n == 1) begin a = 16'h9999; b = 16'h9999; end
            if (done) break;
        end
        chk("hold_lat", n, 5);
        chk("hold_s1", s, 16'h6912);
        chk("hold_cout1", cout, 0);
        m = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            m++;
            if (m == 1) chk("hold_idle_gap", busy, 0);
            if (done) break;
        end
        chk("hold_period", m, 6);
        chk("hold_s2", s, 16'h9998);
        chk("hold_cout2", cout, 1);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("hold_stop", busy, 0);

        // Reset in the second ADD cycle aborts with no done.
        a = 16'h1234; b = 16'h5678; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_s", s, 16'h0002);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_outs", {s, cout, busy, done, err}, 0);
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        run4(16'h2468, 16'h1357, 1'b0, 1'b0, lat, bcnt);
        chk("after_abort_lat", lat, 5);
        chk("after_abort_s", s, 16'h3825);
        chk("after_abort_cout", cout, 0);
        @(negedge clk);

        // DIGITS=1
        a1 = 4'h7; b1 = 4'h5; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done1) begin n = k; break; end
        end
        chk("d1_lat", n, 2);
        chk("d1_s", s1, 4'h2);
        chk("d1_cout", cout1, 1);
        chk("d1_err", err1, 0);
        @(negedge clk);

        // DIGITS=8
        a8 = 32'h99999999; b8 = 32'h00000001; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        n = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done8) begin n = k; break; end
        end
        chk("d8_lat", n, 9);
        chk("d8_s", s8, 0);
        chk("d8_cout", cout8, 1);
        chk("d8_err", err8, 0);
        @(negedge clk);
        chk("d8_idle", busy8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
